// File: rtl/hex_entry_display.sv
// ---------------------------------------------------------------------------
// hex_entry_display
//
// Hex-digit entry and display controller for the keypad/switch path.
// Rising edges on load/bksp/clr edit a DIGITS-wide nibble shift register.
// The stored digits are scanned onto a multiplexed active-low seven-segment
// display, and unused leading digits are blanked.
//
// Parameters
//   DIGITS    : number of hex digits stored and displayed (2..8)
//   SCAN_DIV  : clock cycles each digit stays lit (>= 2)
//   OVERWRITE : 1 = a load while full shifts and drops the MS digit,
//               0 = a load while full is ignored
//
// Ports
//   clk50M  in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   din     in   nibble entered on a load rising edge
//   load    in   level; rising edge enters din as the new LS digit
//   bksp    in   level; rising edge deletes the LS digit
//   clr     in   level; rising edge clears all digits
//   on_off  in   1 = display enabled, 0 = display dark
//   value   out  stored digits, digit 0 in bits [3:0]
//   count   out  number of digits entered
//   full    out  count == DIGITS
//   seg     out  active-low segments, seg[0]=a .. seg[6]=g
//   cat     out  active-low digit enables, one-hot low or all high
// ---------------------------------------------------------------------------
module hex_entry_display #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int OVERWRITE = 0
) (
  input  logic                         clk50M,
  input  logic                         rst,
  input  logic [3:0]                   din,
  input  logic                         load,
  input  logic                         bksp,
  input  logic                         clr,
  input  logic                         on_off,
  output logic [DIGITS*4-1:0]          value,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full,
  output logic [6:0]                   seg,
  output logic [DIGITS-1:0]            cat
);

  localparam int VW = DIGITS * 4;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = $clog2(DIGITS);
  localparam int DW = $clog2(SCAN_DIV);

  // -------------------------------------------------------------------------
  // Entry register and edge detection
  // -------------------------------------------------------------------------
  logic [VW-1:0] r_value;
  logic [CW-1:0] r_count;
  logic          r_load_q;
  logic          r_bksp_q;
  logic          r_clr_q;

  logic w_load_edge;
  logic w_bksp_edge;
  logic w_clr_edge;
  logic w_full;

  assign w_load_edge = load & ~r_load_q;
  assign w_bksp_edge = bksp & ~r_bksp_q;
  assign w_clr_edge  = clr  & ~r_clr_q;
  assign w_full      = (r_count == CW'(DIGITS));

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_value  <= '0;
      r_count  <= '0;
      // History starts high so a level held through reset never fires.
      r_load_q <= 1'b1;
      r_bksp_q <= 1'b1;
      r_clr_q  <= 1'b1;
    end else begin
      r_load_q <= load;
      r_bksp_q <= bksp;
      r_clr_q  <= clr;
      // Only the highest-priority edge acts; the others are dropped.
      if (w_clr_edge) begin
        r_value <= '0;
        r_count <= '0;
      end else if (w_bksp_edge) begin
        if (r_count != '0) begin
          r_value <= {4'h0, r_value[VW-1:4]};
          r_count <= r_count - CW'(1);
        end
      end else if (w_load_edge) begin
        if (!w_full) begin
          r_value <= {r_value[VW-5:0], din};
          r_count <= r_count + CW'(1);
        end else if (OVERWRITE != 0) begin
          r_value <= {r_value[VW-5:0], din};
        end
      end
    end
  end

  assign value = r_value;
  assign count = r_count;
  assign full  = w_full;

  // -------------------------------------------------------------------------
  // Scan divider and digit index (runs even while the display is dark)
  // -------------------------------------------------------------------------
  logic [DW-1:0] r_div;
  logic [IW-1:0] r_idx;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DW'(SCAN_DIV - 1)) begin
      r_div <= '0;
      if (r_idx == IW'(DIGITS - 1)) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Digit select, blanking and decode
  // -------------------------------------------------------------------------
  logic [3:0]        w_digits [DIGITS];
  logic [3:0]        w_digit;
  logic [CW-1:0]     w_shown;
  logic              w_blank;
  logic [6:0]        w_hex_seg;
  logic [6:0]        w_seg_next;
  logic [DIGITS-1:0] w_cat_next;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_digits[gi] = r_value[gi*4 +: 4];
    end
  endgenerate

  assign w_digit = w_digits[r_idx];

  // With nothing entered digit 0 still shows "0", so at least one digit lit.
  assign w_shown = (r_count == '0) ? CW'(1) : r_count;
  assign w_blank = (32'(r_idx) >= 32'(w_shown));

  always_comb begin
    w_hex_seg = 7'h7F;
    case (w_digit)
      4'h0: w_hex_seg = 7'h40;
      4'h1: w_hex_seg = 7'h79;
      4'h2: w_hex_seg = 7'h24;
      4'h3: w_hex_seg = 7'h30;
      4'h4: w_hex_seg = 7'h19;
      4'h5: w_hex_seg = 7'h12;
      4'h6: w_hex_seg = 7'h02;
      4'h7: w_hex_seg = 7'h78;
      4'h8: w_hex_seg = 7'h00;
      4'h9: w_hex_seg = 7'h10;
      4'hA: w_hex_seg = 7'h08;
      4'hB: w_hex_seg = 7'h03;
      4'hC: w_hex_seg = 7'h46;
      4'hD: w_hex_seg = 7'h21;
      4'hE: w_hex_seg = 7'h06;
      4'hF: w_hex_seg = 7'h0E;
      default: w_hex_seg = 7'h7F;
    endcase
  end

  // A blank digit keeps its enable active but drives every segment off.
  always_comb begin
    w_seg_next = 7'h7F;
    w_cat_next = '1;
    if (on_off) begin
      w_cat_next = ~(DIGITS'(1) << r_idx);
      if (!w_blank) begin
        w_seg_next = w_hex_seg;
      end
    end
  end

  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_cat;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_cat <= '1;
    end else begin
      r_seg <= w_seg_next;
      r_cat <= w_cat_next;
    end
  end

  assign seg = r_seg;
  assign cat = r_cat;

endmodule

// File: tb/tb_hex_entry_display.sv
// ---------------------------------------------------------------------------
// tb_hex_entry_display
//
// Two instances (OVERWRITE=0 and OVERWRITE=1, DIGITS=4, SCAN_DIV=4) share
// the same stimulus. The stimulus thread pushes hand-computed expectations
// tagged with the cycle they apply to; a monitor on the falling edge pops
// every expectation that is due and compares it with the DUT output.
// ---------------------------------------------------------------------------
module tb_hex_entry_display;

  logic       clk50M = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] din    = 4'h0;
  logic       load   = 1'b0;
  logic       bksp   = 1'b0;
  logic       clr    = 1'b0;
  logic       on_off = 1'b1;

  logic [15:0] value0, value1;
  logic [2:0]  count0, count1;
  logic        full0, full1;
  logic [6:0]  seg0, seg1;
  logic [3:0]  cat0, cat1;

  hex_entry_display #(.DIGITS(4), .SCAN_DIV(4), .OVERWRITE(0)) dut0 (
    .clk50M(clk50M), .rst(rst), .din(din), .load(load), .bksp(bksp),
    .clr(clr), .on_off(on_off), .value(value0), .count(count0),
    .full(full0), .seg(seg0), .cat(cat0)
  );

  hex_entry_display #(.DIGITS(4), .SCAN_DIV(4), .OVERWRITE(1)) dut1 (
    .clk50M(clk50M), .rst(rst), .din(din), .load(load), .bksp(bksp),
    .clr(clr), .on_off(on_off), .value(value1), .count(count1),
    .full(full1), .seg(seg1), .cat(cat1)
  );

  always #5 clk50M = ~clk50M;

  int cyc = 0;
  always @(posedge clk50M) cyc++;

  // Expectation selectors
  localparam int S_VAL0 = 0, S_CNT0 = 1, S_FULL0 = 2, S_CAT0 = 3, S_SEG0 = 4;
  localparam int S_VAL1 = 5, S_CNT1 = 6, S_FULL1 = 7;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   r0       = 0;   // cycle of the most recent reset edge

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_VAL0:  return 32'(value0);
      S_CNT0:  return 32'(count0);
      S_FULL0: return 32'(full0);
      S_CAT0:  return 32'(cat0);
      S_SEG0:  return 32'(seg0);
      S_VAL1:  return 32'(value1);
      S_CNT1:  return 32'(count1);
      S_FULL1: return 32'(full1);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due at or before this cycle.
  always @(negedge clk50M) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_checks++;
      if (actual(e.sel) === e.exp) begin
        n_pass++;
        $display("cyc %0d check %s ok (%0h)", cyc, e.name, e.exp);
      end else begin
        $display("FAIL %s at cyc %0d: actual=%0h expected=%0h",
                 e.name, cyc, actual(e.sel), e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  task automatic expect_now(int sel, logic [31:0] v, string nm);
    sb_q.push_back('{cyc, sel, v, nm});
  endtask

  task automatic expect_state(int d, logic [15:0] v, int c, string nm);
    if (d == 0) begin
      expect_now(S_VAL0, 32'(v), {nm, ".value0"});
      expect_now(S_CNT0, 32'(c), {nm, ".count0"});
      expect_now(S_FULL0, (c == 4) ? 32'd1 : 32'd0, {nm, ".full0"});
    end else begin
      expect_now(S_VAL1, 32'(v), {nm, ".value1"});
      expect_now(S_CNT1, 32'(c), {nm, ".count1"});
      expect_now(S_FULL1, (c == 4) ? 32'd1 : 32'd0, {nm, ".full1"});
    end
  endtask

  // One low cycle, one high cycle, one low cycle for the selected inputs.
  task automatic pulse(logic ld, logic bk, logic cl, logic [3:0] d);
    load = 1'b0; bksp = 1'b0; clr = 1'b0;
    tick();
    load = ld; bksp = bk; clr = cl; din = d;
    tick();
    load = 1'b0; bksp = 1'b0; clr = 1'b0;
    tick();
  endtask

  task automatic do_reset(string nm);
    rst = 1'b1;
    tick();
    r0 = cyc;
    expect_state(0, 16'h0000, 0, nm);
    expect_now(S_CAT0, 32'hF, {nm, ".cat"});
    expect_now(S_SEG0, 32'h7F, {nm, ".seg"});
    rst = 1'b0;
  endtask

  // Each digit is lit for 4 cycles; index 0 is shown 1..4 cycles after reset.
  task automatic scan_check(int n, logic [6:0] s0, logic [6:0] s1,
                            logic [6:0] s2, logic [6:0] s3, string nm);
    int         idx;
    logic [3:0] c;
    logic [6:0] s;
    for (int k = 0; k < n; k++) begin
      tick();
      idx = ((cyc - r0 - 1) / 4) % 4;
      c   = ~(4'b0001 << idx);
      case (idx)
        0:       s = s0;
        1:       s = s1;
        2:       s = s2;
        default: s = s3;
      endcase
      expect_now(S_CAT0, 32'(c), $sformatf("%s.cat[%0d]", nm, idx));
      expect_now(S_SEG0, 32'(s), $sformatf("%s.seg[%0d]", nm, idx));
    end
  endtask

  initial begin
    tick();
    tick();
    do_reset("reset");

    // Enter 1,2,3
    pulse(1, 0, 0, 4'h1);
    pulse(1, 0, 0, 4'h2);
    pulse(1, 0, 0, 4'h3);
    expect_state(0, 16'h0123, 3, "load123");
    expect_state(1, 16'h0123, 3, "load123");
    scan_check(16, 7'h30, 7'h24, 7'h79, 7'h7F, "scan123");

    // Fill, then load while full
    pulse(1, 0, 0, 4'h4);
    expect_state(0, 16'h1234, 4, "load4");
    expect_state(1, 16'h1234, 4, "load4");
    pulse(1, 0, 0, 4'h5);
    expect_state(0, 16'h1234, 4, "full_ignore");
    expect_state(1, 16'h2345, 4, "full_overwrite");

    // Backspace down past empty
    pulse(0, 1, 0, 4'h0);
    expect_state(0, 16'h0123, 3, "bksp1");
    expect_state(1, 16'h0234, 3, "bksp1");
    pulse(0, 1, 0, 4'h0);
    expect_state(0, 16'h0012, 2, "bksp2");
    pulse(0, 1, 0, 4'h0);
    expect_state(0, 16'h0001, 1, "bksp3");
    pulse(0, 1, 0, 4'h0);
    expect_state(0, 16'h0000, 0, "bksp4");
    expect_state(1, 16'h0000, 0, "bksp4");
    pulse(0, 1, 0, 4'h0);
    expect_state(0, 16'h0000, 0, "bksp_empty");
    scan_check(8, 7'h40, 7'h7F, 7'h7F, 7'h7F, "scan_empty");

    // Coincident edges: clr wins
    pulse(1, 0, 0, 4'h1);
    pulse(1, 0, 0, 4'h2);
    expect_state(0, 16'h0012, 2, "pre_all");
    pulse(1, 1, 1, 4'h9);
    expect_state(0, 16'h0000, 0, "all_edges");
    expect_state(1, 16'h0000, 0, "all_edges");
    pulse(1, 0, 0, 4'hA);
    expect_state(0, 16'h000A, 1, "loadA");
    expect_state(1, 16'h000A, 1, "loadA");

    // Load held high through reset must not enter a digit
    din  = 4'h7;
    load = 1'b1;
    tick();
    do_reset("reset_held");
    tick();
    tick();
    tick();
    load = 1'b0;
    tick();
    expect_state(0, 16'h0000, 0, "held_load");
    pulse(1, 0, 0, 4'h7);
    expect_state(0, 16'h0007, 1, "load7");

    // Dark display while the scan keeps running
    on_off = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      expect_now(S_CAT0, 32'hF, "dark.cat");
      expect_now(S_SEG0, 32'h7F, "dark.seg");
    end
    on_off = 1'b1;
    scan_check(8, 7'h78, 7'h7F, 7'h7F, 7'h7F, "resume");

    // Reset mid-digit restarts the scan at index 0
    tick();
    tick();
    do_reset("reset_mid");
    scan_check(16, 7'h40, 7'h7F, 7'h7F, 7'h7F, "scan_restart");

    // Drain the scoreboard
    tick();
    tick();
    tick();
    if (sb_q.size() != 0) begin
      $display("FAIL drain: actual=%0d pending expectations, expected=0",
               sb_q.size());
      n_checks += sb_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_entry_display.md
Name: hex_entry_display

Overview:
- Parametrised hex-digit entry and display controller for the keypad/switch I/O path.
- Captures 4-bit nibbles into a DIGITS-wide shift register on load edges, and supports backspace and clear.
- Tracks how many digits have been entered and drives a time-multiplexed active-low seven-segment display with leading-digit blanking.
- Supersedes the fixed 4-digit shift register plus display mux pairing.

Parameters:
- DIGITS, 4, number of hex digits stored and displayed (2..8).
- SCAN_DIV, 50000, clk50M cycles each digit stays lit (>=2).
- OVERWRITE, 0, 1 = load while full shifts and discards the MS digit; 0 = load while full is ignored.

Ports:
- clk50M  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  4  nibble to enter; sampled on the load edge cycle.
- load  in  1  level input, already synchronous and debounced; rising edge enters din.
- bksp  in  1  level input; rising edge deletes the least-significant digit.
- clr  in  1  level input; rising edge clears all digits.
- on_off  in  1  1 = display enabled, 0 = display dark.
- value  out  DIGITS*4  stored digits; digit 0 in bits [3:0].
- count  out  $clog2(DIGITS+1)  number of digits entered.
- full  out  1  high when count == DIGITS.
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
- cat  out  DIGITS  active-low digit enables, one-hot or all-high.

Behaviour:
- Reset, synchronous, on the clock edge with rst=1:
  - value=0, count=0, full=0, seg=7'h7F, cat=all 1s.
  - Scan divider=0, scan index=0.
  - Edge-detect history registers are set to 1, so inputs held high through reset do not fire.
- Edge detection: edge_x = x & ~x_q, where x_q is x delayed one cycle.
- Priority when edges coincide in one cycle: clr > bksp > load. Only the highest-priority action executes; the lower-priority edges are dropped.
- clr edge: value=0, count=0 on the next edge.
- bksp edge:
  - count>0: value shifts right one nibble, zero fills the MS nibble, count-1.
  - count==0: no change.
- load edge:
  - count<DIGITS: value = {value[DIGITS*4-5:0], din}, count+1.
  - count==DIGITS and OVERWRITE=1: same shift, MS digit discarded, count stays DIGITS.
  - count==DIGITS and OVERWRITE=0: no change.
- full is combinational from count.
- value/count update latency: 1 cycle after the edge cycle.
- Scan:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and the scan index advances; index wraps DIGITS-1 -> 0.
  - Scanning runs regardless of on_off.
- Blanking: digit i is blank if i >= max(count,1). With count=0, digit 0 shows "0" and the rest are blank.
- seg/cat are registered, 1 cycle after the scan index changes.
  - on_off=1 and digit not blank: cat has a 0 only at the index bit; seg = hex decode of value[4i+3:4i].
  - Digit blank: cat bit stays active, seg=7'h7F.
  - on_off=0: cat=all 1s, seg=7'h7F. Stored state is unaffected.
- Hex decode, active-low g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset asserted mid-scan or mid-edge: rst wins; any pending edge is lost.
- After rst deasserts: a level held high needs a low-then-high transition to act.

Test Plan:
- DIGITS=4, SCAN_DIV=4. Reset, then pulse load with din=1,2,3 -> value=16'h0123, count=3, full=0; scan shows digits 0..2 with seg 30/24/79, digit 3 seg=7F.
- Load din=4,5 with OVERWRITE=0 -> after 4: value=16'h1234, full=1; load 5 ignored, value stays 16'h1234. Repeat with OVERWRITE=1 -> value=16'h2345, count=4.
- From 16'h1234, count=4: bksp edge -> value=16'h0123, count=3; 4 more bksp edges -> value=0, count=0, digit 0 shows 40.
- load, bksp and clr rising in the same cycle from value=16'h0012 -> value=0, count=0 (clr wins); next single load edge with din=A -> value=16'h000A, count=1.
- load held high through rst and released -> no entry; on_off=0 -> cat=4'hF and seg=7F throughout, while the scan index continues cycling every 4 clocks.
- Scan timing: with on_off=1, cat sequence E,D,B,7 with each value held 4 cycles; assert rst mid-digit -> cat=F, index restarts at 0.
